// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns: one 32-bit column per clock, start/busy/done handshake.
// The result is published to state_out in a single update once all four columns are done.
module inv_mix_columns_seq #(
    parameter int word_size  = 8,
    parameter int array_size = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [word_size*array_size-1:0]   state_in,
    output logic [word_size*array_size-1:0]   state_out,
    output logic                              busy,
    output logic                              done
);

    localparam int state_w = word_size * array_size;

    localparam logic [1:0] st_idle = 2'd0;
    localparam logic [1:0] st_run  = 2'd1;

    logic [1:0]         fsm;
    logic [1:0]         col;
    logic [state_w-1:0] work;
    logic [state_w-1:0] next_work;
    logic [31:0]        col_word;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Each byte's x2/x4/x8 chain is shared by all four coefficient products.
    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a, x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [31:0] o;
        for (int r = 0; r < 4; r++) begin
            a     = c[8*r +: 8];
            x2    = xt(a);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[r] = x8 ^ a;
            mb[r] = x8 ^ x2 ^ a;
            md[r] = x8 ^ x4 ^ a;
            me[r] = x8 ^ x4 ^ x2;
        end
        o = '0;
        for (int r = 0; r < 4; r++) begin
            o[8*r +: 8] = me[r] ^ mb[(r + 1) & 3] ^ md[(r + 2) & 3] ^ m9[(r + 3) & 3];
        end
        return o;
    endfunction

    always_comb begin
        col_word  = work[32*col +: 32];
        next_work = work;
        next_work[32*col +: 32] = inv_col(col_word);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= st_idle;
            col       <= 2'd0;
            work      <= '0;
            state_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (fsm)
                st_idle: begin
                    if (start) begin
                        work <= state_in;
                        col  <= 2'd0;
                        busy <= 1'b1;
                        fsm  <= st_run;
                    end
                end
                st_run: begin
                    work <= next_work;
                    col  <= col + 2'd1;
                    // Last column: next_work already holds the complete result.
                    if (col == 2'd3) begin
                        state_out <= next_work;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        fsm       <= st_idle;
                    end
                end
                default: begin
                    fsm  <= st_idle;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: directed FIPS-197 columns, handshake corner cases,
// and random states checked by feeding the result through a forward MixColumns model.
module tb_inv_mix_columns_seq;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] state_in;
    logic [127:0] state_out;
    logic         busy;
    logic         done;

    int n_checks;
    int n_fail;

    logic [127:0] fips_in;
    logic [127:0] fips_out;
    logic [127:0] all_c6;

    inv_mix_columns_seq #(.word_size(8), .array_size(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .state_in  (state_in),
        .state_out (state_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Generic shift-and-add GF(2^8) multiply.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        logic [7:0] b [16];
        logic [7:0] o [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = s[8*i +: 8];
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++)
                o[4*c + k] = gf_mul(8'h02, b[4*c + k]) ^ gf_mul(8'h03, b[4*c + (k+1)%4])
                           ^ b[4*c + (k+2)%4] ^ b[4*c + (k+3)%4];
        for (int i = 0; i < 16; i++) r[8*i +: 8] = o[i];
        return r;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a negedge; the following posedge is the accepting edge E0.
    task automatic launch(input logic [127:0] vec);
        state_in = vec;
        start    = 1'b1;
    endtask

    // Walks through E0..E4; poke>0 raises start (with junk data) at edge E_poke.
    task automatic follow(input string tag, input logic [127:0] exp,
                          input logic [127:0] held, input int poke);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            start = (k == poke);
            if (k == poke) state_in = all_c6;
            check({tag, "_busy"}, busy, 1'b1);
            check({tag, "_done_low"}, done, 1'b0);
            check({tag, "_held"}, state_out, held);
        end
        @(negedge clk);
        start = 1'b0;
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_low"}, busy, 1'b0);
        check({tag, "_result"}, state_out, exp);
    endtask

    task automatic quiet_cycles(input string tag, input int n, input logic [127:0] held);
        int seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check({tag, "_no_done"}, seen, 0);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_hold"}, state_out, held);
    endtask

    initial begin
        logic [127:0] vec;
        logic [127:0] got;
        int           ndone;

        n_checks = 0;
        n_fail   = 0;
        fips_in  = 128'hd6d7d5d5_01010101_9d58dc9f_bca14d8e;
        fips_out = 128'hd5d4d4d4_01010101_5c220af2_455313db;
        all_c6   = {16{8'hc6}};

        // Reset held with start high.
        rst      = 1'b1;
        start    = 1'b1;
        state_in = fips_in;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_state_out", state_out, '0);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
        end
        rst   = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("post_rst_state_out", state_out, '0);
            check("post_rst_busy", busy, 1'b0);
            check("post_rst_done", done, 1'b0);
        end

        // Single FIPS-197 transform.
        launch(fips_in);
        follow("single", fips_out, '0, 0);
        @(negedge clk);
        check("single_done_pulse", done, 1'b0);
        check("single_hold", state_out, fips_out);

        // start re-pulsed at E2 is ignored.
        launch(fips_in);
        follow("ignored", fips_out, fips_out, 2);
        quiet_cycles("ignored", 8, fips_out);

        // Back-to-back: second start in the done cycle.
        launch(fips_in);
        follow("b2b_first", fips_out, fips_out, 0);
        launch(all_c6);
        follow("b2b_second", all_c6, fips_out, 0);
        @(negedge clk);
        check("b2b_done_fall", done, 1'b0);

        // Reset asserted at E2 aborts the transform.
        launch(fips_in);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_state_out", state_out, '0);
        quiet_cycles("abort", 8, '0);

        // Random round-trip with input churn during RUN.
        for (int t = 0; t < 1000; t++) begin
            vec = rand_state();
            launch(vec);
            ndone = 0;
            got   = '0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                start    = 1'b0;
                state_in = rand_state();
                if (done) begin
                    ndone++;
                    got = state_out;
                end
            end
            check("rand_done_count", ndone, 1);
            check("rand_roundtrip", fwd_mix(got), vec);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
